// File: rtl/sdram_req_queue_pkg.sv
// rtl/sdram_req_queue_pkg.sv - shared FSM encodings and helpers for the SDRAM request queue
package sdram_req_queue_pkg;

  typedef enum logic [2:0] {
    STATE_Q_BOOT      = 3'd0,
    STATE_Q_BOOT_WAIT = 3'd1,
    STATE_Q_IDLE      = 3'd2,
    STATE_Q_ISSUE     = 3'd3,
    STATE_Q_WAIT_ACC  = 3'd4,
    STATE_Q_WAIT_RD   = 3'd5,
    STATE_Q_WAIT_WR   = 3'd6
  } state_q_e;

  // True while a request has left the FIFO but the controller has not yet returned to idle.
  function automatic logic is_outstanding(input state_q_e s);
    return (s == STATE_Q_ISSUE) || (s == STATE_Q_WAIT_ACC) ||
           (s == STATE_Q_WAIT_RD) || (s == STATE_Q_WAIT_WR);
  endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// rtl/sdram_req_fifo.sv - circular request buffer with wrap-bit pointers
module sdram_req_fifo #(
  parameter int WIDTH      = 45,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic                do_push;
  logic                do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Pointer update; both advance together on a simultaneous push and pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/sdram_req_queue.sv
// rtl/sdram_req_queue.sv - host request queue and issue sequencer for the SDRAM controller (option: SDRAM_REQ_WR_ACK_EN)
module sdram_req_queue
  import sdram_req_queue_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              busy,
  output logic              ctl_en,
  output logic              ctl_we,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_wdata,
  input  logic              ctl_rdy,
  input  logic [DATA_W-1:0] ctl_rdata,
  input  logic              ctl_valid
);

  localparam int ENTRY_W = ADDR_W + DATA_W + 1;

  state_q_e          state_q, state_d;
  logic              ctl_en_d, ctl_we_d, rsp_valid_d, init_done_d;
  logic [ADDR_W-1:0] ctl_addr_d;
  logic [DATA_W-1:0] ctl_wdata_d, rsp_rdata_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  logic               head_we;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_wdata;

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && !fifo_full;
  assign fifo_din  = {req_we, req_addr, req_wdata};
  assign {head_we, head_addr, head_wdata} = fifo_dout;
  assign busy      = !fifo_empty || is_outstanding(state_q);

  sdram_req_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state and registered-output logic; the controller handshake is tracked through ctl_rdy edges.
  always_comb begin
    state_d     = state_q;
    ctl_en_d    = 1'b0;
    ctl_we_d    = ctl_we;
    ctl_addr_d  = ctl_addr;
    ctl_wdata_d = ctl_wdata;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    init_done_d = init_done;
    fifo_pop    = 1'b0;
    case (state_q)
      STATE_Q_BOOT: begin
        ctl_en_d = 1'b1;
        state_d  = STATE_Q_BOOT_WAIT;
      end
      STATE_Q_BOOT_WAIT: begin
        if (ctl_rdy) begin
          init_done_d = 1'b1;
          state_d     = STATE_Q_IDLE;
        end
      end
      STATE_Q_IDLE: begin
        // Ready already excludes an imminent refresh, so the enable next cycle is safe.
        if (!fifo_empty && ctl_rdy) begin
          fifo_pop    = 1'b1;
          ctl_we_d    = head_we;
          ctl_addr_d  = head_addr;
          ctl_wdata_d = head_wdata;
          ctl_en_d    = 1'b1;
          state_d     = STATE_Q_ISSUE;
        end
      end
      STATE_Q_ISSUE: begin
        state_d = STATE_Q_WAIT_ACC;
      end
      STATE_Q_WAIT_ACC: begin
        if (!ctl_rdy) state_d = ctl_we ? STATE_Q_WAIT_WR : STATE_Q_WAIT_RD;
      end
      STATE_Q_WAIT_RD: begin
        if (ctl_valid) begin
          rsp_rdata_d = ctl_rdata;
          rsp_valid_d = 1'b1;
          state_d     = STATE_Q_WAIT_WR;
        end
      end
      STATE_Q_WAIT_WR: begin
        if (ctl_rdy) begin
          state_d = STATE_Q_IDLE;
`ifdef SDRAM_REQ_WR_ACK_EN
          rsp_valid_d = ctl_we;
`endif
        end
      end
      default: state_d = STATE_Q_BOOT;
    endcase
  end

  // State and output registers; reset aborts any access and restarts the boot sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= STATE_Q_BOOT;
      ctl_en    <= 1'b0;
      ctl_we    <= 1'b0;
      ctl_addr  <= '0;
      ctl_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctl_en    <= ctl_en_d;
      ctl_we    <= ctl_we_d;
      ctl_addr  <= ctl_addr_d;
      ctl_wdata <= ctl_wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      init_done <= init_done_d;
    end
  end

endmodule

// File: tb/tb_sdram_req_queue.sv
// tb/tb_sdram_req_queue.sv - scoreboard bench for sdram_req_queue with a behavioural controller
module tb_sdram_req_queue;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              init_done;
  logic              busy;
  logic              ctl_en;
  logic              ctl_we;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_wdata;
  logic              ctl_rdy;
  logic [DATA_W-1:0] ctl_rdata;
  logic              ctl_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_req_queue #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .init_done (init_done),
    .busy      (busy),
    .ctl_en    (ctl_en),
    .ctl_we    (ctl_we),
    .ctl_addr  (ctl_addr),
    .ctl_wdata (ctl_wdata),
    .ctl_rdy   (ctl_rdy),
    .ctl_rdata (ctl_rdata),
    .ctl_valid (ctl_valid)
  );

  // Controller model: ready 20 cycles after reset, each access holds ready low for 6 cycles.
  logic              m_rdy;
  logic              m_valid;
  logic [DATA_W-1:0] m_rdata;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  int                m_phase;
  int                m_cnt;
  logic [DATA_W-1:0] ctl_mem [0:(1<<ADDR_W)-1];
  logic              hold_off = 1'b0;
  logic              inject_valid = 1'b0;

  assign ctl_rdy   = m_rdy && !hold_off;
  assign ctl_valid = m_valid || inject_valid;
  assign ctl_rdata = m_rdata;

  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (!rst_n) begin
      m_rdy   <= 1'b0;
      m_phase <= 0;
      m_cnt   <= 0;
      m_rdata <= '0;
    end else begin
      case (m_phase)
        0: begin
          m_cnt <= m_cnt + 1;
          if (m_cnt == 19) begin
            m_rdy   <= 1'b1;
            m_phase <= 1;
          end
        end
        1: begin
          if (ctl_en) begin
            checks++;
            if (!ctl_rdy) begin
              errors++;
              $display("FAIL en_when_not_ready: ctl_en=1 while ctl_rdy=%0b, required ctl_rdy=1", ctl_rdy);
            end
            m_we    <= ctl_we;
            m_addr  <= ctl_addr;
            m_wdata <= ctl_wdata;
            m_rdy   <= 1'b0;
            m_cnt   <= 0;
            m_phase <= 2;
          end
        end
        default: begin
          m_cnt <= m_cnt + 1;
          if (ctl_en) begin
            errors++;
            $display("FAIL en_while_busy: ctl_en=1 during access, required 0");
          end
          if (m_cnt == 3) begin
            if (m_we) ctl_mem[m_addr] <= m_wdata;
            else begin
              m_valid <= 1'b1;
              m_rdata <= ctl_mem[m_addr];
            end
          end
          if (m_cnt == 5) begin
            m_rdy   <= 1'b1;
            m_phase <= 1;
          end
        end
      endcase
    end
  end

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t              exp_issue[$];
  logic [DATA_W-1:0] exp_rsp[$];
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] last_rd_exp = '0;
  int                boot_en_cnt = 0;
  int                issue_cnt = 0;
  int                rsp_cnt = 0;
  req_t              mon_r;
  logic [DATA_W-1:0] mon_d;

  // Monitor: every controller enable and every response is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ctl_en) begin
        if (!init_done) boot_en_cnt++;
        else begin
          issue_cnt++;
          checks++;
          if (exp_issue.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ctl_en: we=%0b addr=%h, required no enable", ctl_we, ctl_addr);
          end else begin
            mon_r = exp_issue.pop_front();
            if ({ctl_we, ctl_addr, ctl_wdata} !== {mon_r.we, mon_r.addr, mon_r.wdata}) begin
              errors++;
              $display("FAIL issue: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                       ctl_we, ctl_addr, ctl_wdata, mon_r.we, mon_r.addr, mon_r.wdata);
            end
          end
        end
      end
      if (rsp_valid) begin
        rsp_cnt++;
        checks++;
        if (exp_rsp.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: rsp_rdata=%h, required no rsp_valid", rsp_rdata);
        end else begin
          mon_d = exp_rsp.pop_front();
          if (rsp_rdata !== mon_d) begin
            errors++;
            $display("FAIL rsp_data: got %h, required %h", rsp_rdata, mon_d);
          end
        end
      end
    end
  end

  task automatic push_req(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    int   n;
    req_t r;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: req_ready=%0b, required 1", req_ready);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      r.we = we;
      r.addr = addr;
      r.wdata = wdata;
      exp_issue.push_back(r);
      if (we) begin
        ref_mem[addr] = wdata;
`ifdef SDRAM_REQ_WR_ACK_EN
        exp_rsp.push_back(last_rd_exp);
`endif
      end else begin
        last_rd_exp = ref_mem[addr];
        exp_rsp.push_back(ref_mem[addr]);
      end
    end
  endtask

  task automatic idle_req();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy || exp_issue.size() != 0 || exp_rsp.size() != 0) begin
      errors++;
      $display("FAIL drain: busy=%0b pending_issue=%0d pending_rsp=%0d, required 0/0/0",
               busy, exp_issue.size(), exp_rsp.size());
    end
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (!init_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!init_done) begin
      errors++;
      $display("FAIL init_timeout: init_done=%0b, required 1", init_done);
    end
  endtask

  task automatic test_reset();
    int n;
    int rdy_at;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_valid, ctl_en, ctl_we, init_done, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: rsp_valid/ctl_en/ctl_we/init_done/busy=%b, required 00000",
               {rsp_valid, ctl_en, ctl_we, init_done, busy});
    end
    checks++;
    if ({ctl_addr, ctl_wdata, rsp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, required zeros", ctl_addr, ctl_wdata, rsp_rdata);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%0b, required 1", req_ready);
    end
    boot_en_cnt = 0;
    last_rd_exp = '0;
    rst_n = 1'b1;
    n = 0;
    rdy_at = -1;
    while (!init_done && n < 200) begin
      @(negedge clk);
      n++;
      if (ctl_rdy && rdy_at < 0) rdy_at = n;
    end
    checks++;
    if (!init_done || (n - rdy_at) != 1) begin
      errors++;
      $display("FAIL init_latency: init_done=%0b after %0d cycles from ctl_rdy, required 1 after 1", init_done, n - rdy_at);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (boot_en_cnt !== 1) begin
      errors++;
      $display("FAIL boot_pulses: got %0d, required 1", boot_en_cnt);
    end
  endtask

  task automatic test_write_read();
    int i0, r0;
    i0 = issue_cnt;
    r0 = rsp_cnt;
    push_req(1'b1, 12'h123, 32'hDEADBEEF);
    push_req(1'b0, 12'h123, 32'h0);
    idle_req();
    wait_drain();
    checks++;
    if (issue_cnt - i0 != 2) begin
      errors++;
      $display("FAIL wr_rd_issues: got %0d, required 2", issue_cnt - i0);
    end
    checks++;
`ifdef SDRAM_REQ_WR_ACK_EN
    if (rsp_cnt - r0 != 2) begin
      errors++;
      $display("FAIL wr_rd_rsps: got %0d, required 2", rsp_cnt - r0);
    end
`else
    if (rsp_cnt - r0 != 1) begin
      errors++;
      $display("FAIL wr_rd_rsps: got %0d, required 1", rsp_cnt - r0);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int   i0;
    logic stuck;
    i0 = issue_cnt;
    @(negedge clk);
    hold_off = 1'b1;
    push_req(1'b1, 12'h010, 32'h11110000);
    push_req(1'b1, 12'h020, 32'h22220000);
    push_req(1'b0, 12'h010, 32'h0);
    push_req(1'b1, 12'h030, 32'h33330000);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: req_ready=%0b after 4 pushes, required 0", req_ready);
    end
    stuck = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (req_ready !== 1'b0) stuck = 1'b0;
    end
    checks++;
    if (!stuck) begin
      errors++;
      $display("FAIL full_hold: req_ready rose while full and held off, required 0");
    end
    hold_off = 1'b0;
    push_req(1'b0, 12'h020, 32'h0);
    push_req(1'b0, 12'h030, 32'h0);
    push_req(1'b1, 12'h010, 32'h44440000);
    push_req(1'b0, 12'h010, 32'h0);
    idle_req();
    wait_drain();
    checks++;
    if (issue_cnt - i0 != 8) begin
      errors++;
      $display("FAIL b2b_issues: got %0d, required 8", issue_cnt - i0);
    end
  endtask

  task automatic test_refresh();
    int i0;
    @(negedge clk);
    hold_off = 1'b1;
    push_req(1'b0, 12'h020, 32'h0);
    idle_req();
    i0 = issue_cnt;
    repeat (6) @(negedge clk);
    checks++;
    if (issue_cnt != i0 || ctl_en !== 1'b0) begin
      errors++;
      $display("FAIL refresh_hold: %0d enables while ctl_rdy=0, required 0", issue_cnt - i0);
    end
    hold_off = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl_en !== 1'b1) begin
      errors++;
      $display("FAIL refresh_resume: ctl_en=%0b one cycle after ctl_rdy, required 1", ctl_en);
    end
    wait_drain();
  endtask

  task automatic test_reset_midop();
    int n, r0;
    push_req(1'b0, 12'h123, 32'h0);
    push_req(1'b0, 12'h010, 32'h0);
    idle_req();
    n = 0;
    while (!(ctl_en && init_done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(ctl_en && init_done)) begin
      checks++;
      errors++;
      $display("FAIL midop_issue_timeout: ctl_en=%0b, required 1", ctl_en);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    exp_issue.delete();
    exp_rsp.delete();
    last_rd_exp = '0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy, ctl_en, init_done} !== 4'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midop_reset: rsp_valid/busy/ctl_en/init_done=%b req_ready=%0b, required 0000 and 1",
               {rsp_valid, busy, ctl_en, init_done}, req_ready);
    end
    boot_en_cnt = 0;
    rst_n = 1'b1;
    push_req(1'b1, 12'h055, 32'hCAFEF00D);
    idle_req();
    r0 = rsp_cnt;
    inject_valid = 1'b1;
    repeat (2) @(negedge clk);
    inject_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_cnt != r0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL stray_valid: %0d responses init_done=%0b during boot, required 0 and 0", rsp_cnt - r0, init_done);
    end
    push_req(1'b0, 12'h055, 32'h0);
    idle_req();
    wait_init();
    wait_drain();
    checks++;
    if (boot_en_cnt !== 1) begin
      errors++;
      $display("FAIL reboot_pulses: got %0d, required 1", boot_en_cnt);
    end
  endtask

  task automatic test_wr_ack();
    int r0;
    r0 = rsp_cnt;
    push_req(1'b1, 12'h0A0, 32'h0000A0A0);
    push_req(1'b1, 12'h0B0, 32'h0000B0B0);
    push_req(1'b1, 12'h0C0, 32'h0000C0C0);
    idle_req();
    wait_drain();
    checks++;
`ifdef SDRAM_REQ_WR_ACK_EN
    if (rsp_cnt - r0 != 3) begin
      errors++;
      $display("FAIL wr_ack_count: got %0d, required 3", rsp_cnt - r0);
    end
`else
    if (rsp_cnt - r0 != 0) begin
      errors++;
      $display("FAIL wr_ack_count: got %0d, required 0", rsp_cnt - r0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_refresh();
    test_reset_midop();
    test_wr_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
